instruction_encoder_writer: RTL and testbench
=============================================

Name: instruction_encoder_writer

Overview:
Inverse of the instruction decoder. Accepts decoded instruction fields (op, rdest, rsrc, immediate, r_or_i) over a valid/ready stream. Packs each set into a 16-bit machine word, range-checks it, and writes it sequentially into instruction memory from a programmable base address. Used by the program-load path (UART/debug loader), so a host can download programs as field tuples rather than raw words.

Parameters:
ADDR_W, 10, instruction memory address width; memory depth is 2^ADDR_W words.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; one clock, synchronous active-high reset
start  input  1  one-cycle pulse; begins a load session (sampled only in IDLE)
base_addr  input  ADDR_W  first memory address of the session, latched on start
in_valid  input  1  field tuple present
in_ready  output  1  block can accept a tuple this cycle
in_op  input  8  {major[3:0], ext/cond[3:0]}
in_rdest  input  4  destination register field
in_rsrc  input  4  source register field
in_imm  input  16  immediate, two's complement
in_r_or_i  input  1  0 = register format, 1 = immediate format
in_last  input  1  tuple is final of session
mem_we  output  1  instruction memory write strobe
mem_addr  output  ADDR_W  write address
mem_data  output  16  encoded word
busy  output  1  high in RUN/WRITE
done  output  1  one-cycle pulse on successful session end
error  output  1  sticky until next start or reset
err_code  output  2  00 none, 01 immediate out of range, 10 illegal format, 11 address overflow
count  output  ADDR_W+1  words written this session

Behaviour:
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_data=0, busy=0, done=0, error=0, err_code=00, count=0, state=IDLE. Reset mid-session aborts immediately. No further writes occur and no done pulse is issued.
- States: IDLE, RUN, WRITE, DONE, ERROR.
- IDLE: in_ready=0. When start=1, latch base_addr into mem_addr, clear count/error/err_code, and go to RUN.
- RUN: in_ready=1. A handshake occurs when in_valid & in_ready. On handshake, encode and check the tuple:
  - legal: register the word in mem_data and go to WRITE.
  - illegal: set error/err_code, go to ERROR, no write.
  - No handshake: stay in RUN.
- Encoding rules (major = in_op[7:4], minor = in_op[3:0]):
  - r_or_i=0: word = {major, rdest, minor, rsrc}. This covers R-type, shifts, LOAD/STOR, switch loads, encoder pulls and transmit.
  - r_or_i=1, major=1100 (branch/jump): word = {1100, minor, imm[7:0]}; rdest and rsrc are ignored.
  - r_or_i=1, other major: word = {major, rdest, imm[7:0]}; minor and rsrc are ignored.
- Range check when r_or_i=1: in_imm[15:7] must be all 0 or all 1. Otherwise err_code=01.
- Illegal format: r_or_i=1 with major=0000. This decodes as R-type, so it sets err_code=10.
- If a tuple is both out of range and illegal format, err_code=10 takes priority.
- WRITE: mem_we=1 for exactly one cycle with mem_addr and mem_data stable. count increments by 1 at the end of the cycle. Next state:
  - tuple was in_last: go to DONE, mem_addr unchanged.
  - else if mem_addr == 2^ADDR_W-1: err_code=11, go to ERROR. This is a wrap attempt; the address must never wrap to 0.
  - else: mem_addr+1, go to RUN.
- Latency: handshake in cycle N gives mem_we in cycle N+1. Throughput is one tuple per 2 cycles; in_ready is low during WRITE.
- DONE: done=1 for one cycle, then IDLE.
- ERROR: in_ready=0, error=1 held. start returns the block to RUN with a fresh session, same as from IDLE.
- start while busy (RUN/WRITE) is ignored.
- in_last on the top address completes normally; no overflow error is raised.
- busy=1 only in RUN and WRITE.
- mem_data holds its last value outside WRITE.

Test Plan:
- Reset, then start with base_addr=0x010. Send in order, with last on the third:
  - op=0x05, rdest=3, rsrc=5, r_or_i=0 -> mem_we @0x010 data 0x0355.
  - op=0x50, rdest=2, imm=0xFFFD, r_or_i=1 -> @0x011 0x52FD.
  - op=0xC1, imm=0x0010, r_or_i=1 -> @0x012 0xC110.
  - Then done pulse; count=3.
- Shift/load formats: op=0x84, rdest=1, rsrc=2 -> 0x8142; op=0x40, rdest=7, rsrc=4 -> 0x4704. Writes are one cycle after handshake, and in_ready is low in the write cycle.
- Range: op=0x50, imm=0x0080 -> no mem_we, error=1, err_code=01. Then imm=0xFF80 after a new start -> 0x5x80 written (x = rdest).
- Illegal: op=0x05, r_or_i=1 -> err_code=10, no write. A later start clears error and err_code.
- Overflow (ADDR_W=4): base=0xE, three non-last tuples -> writes @0xE and @0xF, then err_code=11. The third tuple is not accepted.
- Assert reset during WRITE -> next cycle mem_we=0, busy=0, count=0, no done. in_valid held high is not accepted until a new start.

Source files
------------

// File: rtl/instruction_encoder_writer.sv
// Instruction encoder/writer: packs decoded field tuples into 16-bit machine
// words, range-checks them and writes them sequentially into instruction
// memory starting at a programmable base address.
module instruction_encoder_writer #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_op,
    input  logic [3:0]        in_rdest,
    input  logic [3:0]        in_rsrc,
    input  logic [15:0]       in_imm,
    input  logic              in_r_or_i,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        WRITE,
        DONE,
        ERROR
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_RANGE = 2'b01;
    localparam logic [1:0] ERR_FMT   = 2'b10;
    localparam logic [1:0] ERR_OVF   = 2'b11;

    state_t      state;
    logic        last_q;
    logic [3:0]  major;
    logic [3:0]  minor;
    logic [15:0] word;
    logic [1:0]  chk_code;
    logic        imm_ok;

    // Encode the presented tuple and classify it; format error outranks range error
    always_comb begin
        major    = in_op[7:4];
        minor    = in_op[3:0];
        word     = '0;
        chk_code = ERR_NONE;
        imm_ok   = (&in_imm[15:7]) | ~(|in_imm[15:7]);
        if (!in_r_or_i) begin
            word = {major, in_rdest, minor, in_rsrc};
        end else if (major == 4'hC) begin
            word = {4'hC, minor, in_imm[7:0]};
        end else begin
            word = {major, in_rdest, in_imm[7:0]};
        end
        if (in_r_or_i && major == 4'h0) begin
            chk_code = ERR_FMT;
        end else if (in_r_or_i && !imm_ok) begin
            chk_code = ERR_RANGE;
        end
    end

    // Session FSM with all outputs registered alongside the state
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            err_code <= ERR_NONE;
            count    <= '0;
            last_q   <= 1'b0;
        end else begin
            case (state)
                IDLE, ERROR: begin
                    done <= 1'b0;
                    if (start) begin
                        state    <= RUN;
                        mem_addr <= base_addr;
                        count    <= '0;
                        error    <= 1'b0;
                        err_code <= ERR_NONE;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        if (chk_code != ERR_NONE) begin
                            state    <= ERROR;
                            error    <= 1'b1;
                            err_code <= chk_code;
                            busy     <= 1'b0;
                        end else begin
                            state    <= WRITE;
                            mem_data <= word;
                            mem_we   <= 1'b1;
                            last_q   <= in_last;
                        end
                    end
                end
                WRITE: begin
                    mem_we <= 1'b0;
                    count  <= count + (ADDR_W + 1)'(1);
                    if (last_q) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (mem_addr == '1) begin
                        // Never wrap to address 0: a further tuple would need it
                        state    <= ERROR;
                        error    <= 1'b1;
                        err_code <= ERR_OVF;
                        busy     <= 1'b0;
                    end else begin
                        state    <= RUN;
                        mem_addr <= mem_addr + ADDR_W'(1);
                        in_ready <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    mem_we   <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_encoder_writer.sv
// Scoreboard bench for instruction_encoder_writer: stimulus pushes expected
// memory writes into a queue, a negedge monitor pops and compares them.
module tb_instruction_encoder_writer;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_op = '0;
    logic [3:0]    in_rdest = '0;
    logic [3:0]    in_rsrc = '0;
    logic [15:0]   in_imm = '0;
    logic          in_r_or_i = 1'b0;
    logic          in_last = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_data;
    logic          busy;
    logic          done;
    logic          error;
    logic [1:0]    err_code;
    logic [AW:0]   count;

    int vectors = 0;
    int miscompares = 0;
    logic [AW+15:0] exp_q[$];

    instruction_encoder_writer #(.ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rdest(in_rdest), .in_rsrc(in_rsrc), .in_imm(in_imm),
        .in_r_or_i(in_r_or_i), .in_last(in_last), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy), .done(done),
        .error(error), .err_code(err_code), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the head of the scoreboard
    always @(negedge clk) begin
        if (mem_we) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write", mem_addr, mem_data);
            end else begin
                logic [AW+15:0] e;
                e = exp_q.pop_front();
                check("wr_addr", int'(mem_addr), int'(e[AW+15:16]));
                check("wr_data", int'(mem_data), int'(e[15:0]));
                check("wr_in_ready_low", int'(in_ready), 0);
            end
        end
    end

    task automatic do_start(input logic [AW-1:0] base);
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = base;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Present one tuple, wait for the handshake; optionally expect a write
    task automatic send(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs,
                        input logic [15:0] imm, input logic ri, input logic last,
                        input logic wr, input logic [AW-1:0] addr, input logic [15:0] data);
        bit ok = 0;
        if (wr) exp_q.push_back({addr, data});
        in_op = op; in_rdest = rd; in_rsrc = rs; in_imm = imm;
        in_r_or_i = ri; in_last = last; in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            check("handshake_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last = 1'b0;
        @(negedge clk);
        check("write_latency", int'(mem_we), int'(wr));
    endtask

    task automatic wait_done(input int exp_count);
        bit seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) begin seen = 1; break; end
        end
        check("done_pulse", int'(seen), 1);
        check("done_count", int'(count), exp_count);
        check("done_error", int'(error), 0);
        @(negedge clk);
        check("done_one_cycle", int'(done), 0);
        check("idle_busy", int'(busy), 0);
    endtask

    task automatic check_error(input logic [1:0] code, input int exp_count);
        @(negedge clk);
        check("err_flag", int'(error), 1);
        check("err_code", int'(err_code), int'(code));
        check("err_busy", int'(busy), 0);
        check("err_in_ready", int'(in_ready), 0);
        check("err_count", int'(count), exp_count);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_mem_we", int'(mem_we), 0);
        check("rst_mem_addr", int'(mem_addr), 0);
        check("rst_mem_data", int'(mem_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_error", int'(error), 0);
        check("rst_err_code", int'(err_code), 0);
        check("rst_count", int'(count), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Basic session: register, immediate and branch formats
        do_start(10'h010);
        @(negedge clk);
        check("run_busy", int'(busy), 1);
        check("run_in_ready", int'(in_ready), 1);
        check("run_base", int'(mem_addr), 'h010);
        send(8'h05, 4'd3, 4'd5, 16'h0000, 1'b0, 1'b0, 1'b1, 10'h010, 16'h0355);
        send(8'h50, 4'd2, 4'd9, 16'hFFFD, 1'b1, 1'b0, 1'b1, 10'h011, 16'h52FD);
        send(8'hC1, 4'd9, 4'd6, 16'h0010, 1'b1, 1'b1, 1'b1, 10'h012, 16'hC110);
        wait_done(3);

        // Shift / load formats
        do_start(10'h020);
        send(8'h84, 4'd1, 4'd2, 16'h0000, 1'b0, 1'b0, 1'b1, 10'h020, 16'h8142);
        send(8'h40, 4'd7, 4'd4, 16'h0000, 1'b0, 1'b1, 1'b1, 10'h021, 16'h4704);
        wait_done(2);

        // Immediate range: +128 rejected, -128 accepted
        do_start(10'h030);
        send(8'h50, 4'd6, 4'd0, 16'h0080, 1'b1, 1'b0, 1'b0, '0, '0);
        check_error(2'b01, 0);
        do_start(10'h031);
        @(negedge clk);
        check("restart_err_clr", int'(error), 0);
        check("restart_code_clr", int'(err_code), 0);
        send(8'h50, 4'd6, 4'd0, 16'hFF80, 1'b1, 1'b1, 1'b1, 10'h031, 16'h5680);
        wait_done(1);

        // Illegal format, also out of range: format code wins
        do_start(10'h040);
        send(8'h05, 4'd1, 4'd1, 16'h0100, 1'b1, 1'b0, 1'b0, '0, '0);
        check_error(2'b10, 0);
        do_start(10'h040);
        @(negedge clk);
        check("fmt_err_clr", int'(error), 0);
        check("fmt_code_clr", int'(err_code), 0);
        send(8'h21, 4'd4, 4'd7, 16'h0000, 1'b0, 1'b1, 1'b1, 10'h040, 16'h2417);
        wait_done(1);

        // Address overflow: writes at the last two addresses, then no wrap
        do_start(10'h3FE);
        send(8'h13, 4'd1, 4'd2, 16'h0000, 1'b0, 1'b0, 1'b1, 10'h3FE, 16'h1132);
        send(8'h7A, 4'hB, 4'd0, 16'h0005, 1'b1, 1'b0, 1'b1, 10'h3FF, 16'h7B05);
        check_error(2'b11, 2);
        in_valid = 1'b1;
        repeat (4) @(negedge clk);
        check("ovf_no_accept", int'(in_ready), 0);
        check("ovf_addr_hold", int'(mem_addr), 'h3FF);
        in_valid = 1'b0;

        // Last tuple on the top address completes normally
        do_start(10'h3FF);
        send(8'h13, 4'd1, 4'd2, 16'h0000, 1'b0, 1'b1, 1'b1, 10'h3FF, 16'h1132);
        wait_done(1);

        // Reset during WRITE aborts the session
        do_start(10'h050);
        send(8'h13, 4'd1, 4'd2, 16'h0000, 1'b0, 1'b0, 1'b1, 10'h050, 16'h1132);
        reset = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        check("abort_mem_we", int'(mem_we), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_count", int'(count), 0);
        check("abort_done", int'(done), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_in_ready", int'(in_ready), 0);
            check("abort_no_done", int'(done), 0);
        end
        in_valid = 1'b0;

        repeat (2) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
